// File: rtl/fft_qpsk_demap_pkg.sv
// Shared constants, state encoding and bank-word helpers for the FFT QPSK demapper.
package fft_qpsk_demap_pkg;
  localparam int NUM_BINS   = 1024;
  localparam int BANK_DEPTH = 512;
  localparam int ADDR_W     = 11;
  localparam int SAMPLE_W   = 16;
  localparam int WORD_W     = 32;
  localparam int BIN_W      = $clog2(NUM_BINS);
  localparam int BANK_BIT   = $clog2(BANK_DEPTH);

  // Bank words carry the real part in the upper half, imaginary in the lower half.
  localparam int RE_MSB = WORD_W - 1;
  localparam int RE_LSB = SAMPLE_W;
  localparam int IM_MSB = SAMPLE_W - 1;
  localparam int IM_LSB = 0;

  typedef enum logic [1:0] {ST_IDLE, ST_GRAB, ST_READ, ST_DRAIN} state_e;

  // Hard QPSK decision {b1, b0}; zero counts as non-negative.
  function automatic logic [1:0] qpsk_decide(input logic [WORD_W-1:0] word);
    logic signed [SAMPLE_W-1:0] re;
    logic signed [SAMPLE_W-1:0] im;
    re = word[RE_MSB:RE_LSB];
    im = word[IM_MSB:IM_LSB];
    return {re < 0, im < 0};
  endfunction
endpackage

// File: rtl/fft_qpsk_demap_byte_fifo.sv
// First-word-fall-through byte FIFO with an occupancy count for upstream credit.
module fft_qpsk_demap_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [7:0]              din,
  input  logic                    pop,
  output logic [7:0]              dout,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    // NOTE: every signal gets a default first so no path through this block infers a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && (count_q != FULL_CNT);
    do_pop   = pop && (count_q != '0);
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      // NOTE: the storage is reset too, so the head word (m_data) reads 0 rather than X out of reset.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop updating from the same pre-edge values.
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;
endmodule

// File: rtl/fft_qpsk_demap.sv
// Reads FFT bins from the two result banks, makes hard QPSK decisions and packs
// four symbols per byte onto a valid/ready stream.
module fft_qpsk_demap
  import fft_qpsk_demap_pkg::*;
#(
  parameter int FIRST_BIN    = 0,
  parameter int LAST_BIN     = 1023,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_sel,
  output logic              oce0,
  output logic              oce1,
  output logic              ce0,
  output logic              ce1,
  output logic              wre0,
  output logic              wre1,
  output logic [ADDR_W-1:0] ad0,
  output logic [ADDR_W-1:0] ad1,
  output logic [WORD_W-1:0] din0,
  output logic [WORD_W-1:0] din1,
  input  logic [WORD_W-1:0] dout0,
  input  logic [WORD_W-1:0] dout1,
  output logic [7:0]        m_data,
  output logic              m_valid,
  input  logic              m_ready
);
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int SYM_CAP = 4 * FIFO_DEPTH;
  localparam int USE_W   = $clog2(SYM_CAP + READ_LATENCY + 4) + 1;

  state_e                  state_q, state_d;
  logic [BIN_W-1:0]        k_q, k_d;
  logic [ADDR_W-1:0]       ad0_q, ad0_d, ad1_q, ad1_d;
  logic                    done_q, done_d;
  logic [READ_LATENCY-1:0] vld_q, vld_d, bank_q, bank_d;
  logic [5:0]              pack_q, pack_d;
  logic [1:0]              pack_cnt_q, pack_cnt_d;

  logic              issue, issue_bank, ce0_c, ce1_c;
  logic [ADDR_W-1:0] issue_addr;
  logic [USE_W-1:0]  in_flight, used;
  logic              ret_vld;
  logic [1:0]        sym;
  logic              push;
  logic [7:0]        push_data;
  logic              fifo_empty, pop;
  logic [CNT_W-1:0]  fifo_count;

  // Symbols already committed downstream of the issue point; issue only while they fit the FIFO.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < READ_LATENCY; i++) in_flight = in_flight + USE_W'(vld_q[i]);
    used = USE_W'({fifo_count, 2'b00}) + in_flight + USE_W'(pack_cnt_q);
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    done_d  = 1'b0;
    issue   = 1'b0;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_GRAB;
      ST_GRAB: begin
        k_d     = BIN_W'(FIRST_BIN);
        state_d = ST_READ;
      end
      ST_READ: if (used < USE_W'(SYM_CAP)) begin
        issue = 1'b1;
        k_d   = k_q + 1'b1;
        if (k_q == BIN_W'(LAST_BIN)) state_d = ST_DRAIN;
      end
      ST_DRAIN: if ((vld_q == '0) && (pack_cnt_q == '0) && fifo_empty) begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    issue_bank = k_q[BANK_BIT];
    issue_addr = ADDR_W'(k_q[BANK_BIT-1:0]);
    ce0_c      = issue && !issue_bank;
    ce1_c      = issue && issue_bank;
    ad0_d      = ce0_c ? issue_addr : ad0_q;
    ad1_d      = ce1_c ? issue_addr : ad1_q;
    vld_d      = vld_q << 1;
    bank_d     = bank_q << 1;
    vld_d[0]   = issue;
    bank_d[0]  = issue_bank;
  end

  // The bank tag travels with the read so the return word comes from the bank that was addressed.
  always_comb begin
    ret_vld    = vld_q[READ_LATENCY-1];
    sym        = qpsk_decide(bank_q[READ_LATENCY-1] ? dout1 : dout0);
    pack_d     = pack_q;
    pack_cnt_d = pack_cnt_q;
    push       = 1'b0;
    push_data  = {pack_q, sym};
    if (ret_vld) begin
      if (pack_cnt_q == 2'd3) begin
        push       = 1'b1;
        pack_cnt_d = 2'd0;
      end else begin
        pack_d     = {pack_q[3:0], sym};
        pack_cnt_d = pack_cnt_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      ad0_q      <= '0;
      ad1_q      <= '0;
      done_q     <= 1'b0;
      vld_q      <= '0;
      bank_q     <= '0;
      pack_q     <= '0;
      pack_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      ad0_q      <= ad0_d;
      ad1_q      <= ad1_d;
      done_q     <= done_d;
      vld_q      <= vld_d;
      bank_q     <= bank_d;
      pack_q     <= pack_d;
      pack_cnt_q <= pack_cnt_d;
    end
  end

  fft_qpsk_demap_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_data),
    .pop   (pop),
    .dout  (m_data),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign pop     = m_valid && m_ready;
  assign m_valid = !fifo_empty;
  assign busy    = (state_q != ST_IDLE);
  assign mem_sel = !busy;
  assign done    = done_q;
  assign ce0     = ce0_c;
  assign ce1     = ce1_c;
  assign ad0     = ad0_d;
  assign ad1     = ad1_d;
  assign oce0    = 1'b1;
  assign oce1    = 1'b1;
  assign wre0    = 1'b0;
  assign wre1    = 1'b0;
  assign din0    = '0;
  assign din1    = '0;
endmodule

// File: tb/tb_fft_qpsk_demap.sv
// Scoreboard bench: stimulus queues expected bytes, negedge monitors pop and compare.
module tb_fft_qpsk_demap;
  logic clk = 1'b0;
  logic rst;

  logic        start_a, busy_a, done_a, mem_sel_a, oce0_a, oce1_a, ce0_a, ce1_a, wre0_a, wre1_a;
  logic [10:0] ad0_a, ad1_a;
  logic [31:0] din0_a, din1_a, dout0_a, dout1_a;
  logic [7:0]  m_data_a;
  logic        m_valid_a, m_ready_a;

  logic        start_b, busy_b, done_b, mem_sel_b, oce0_b, oce1_b, ce0_b, ce1_b, wre0_b, wre1_b;
  logic [10:0] ad0_b, ad1_b;
  logic [31:0] din0_b, din1_b, dout0_b, dout1_b;
  logic [7:0]  m_data_b;
  logic        m_valid_b, m_ready_b;

  logic [31:0] mem0 [512];
  logic [31:0] mem1 [512];
  logic [31:0] s0_a, s1_a, s0_b, s1_b;

  int n_checks = 0;
  int n_err    = 0;
  logic [7:0]  exp_a [$];
  logic [7:0]  exp_b [$];
  logic [10:0] ad0_log [$];
  logic [10:0] ad1_log [$];
  int bytes_a = 0, done_cnt_a = 0, ce_cnt_a = 0;
  int bytes_b = 0, done_cnt_b = 0, ce0_cnt_b = 0, ce_order_bad = 0, ce_both_b = 0;
  bit   rnd_ready = 1'b0;
  logic ready_val = 1'b1;
  logic       hold_pend_a = 1'b0;
  logic [7:0] hold_data_a = '0;

  always #5 clk = ~clk;

  fft_qpsk_demap u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a), .mem_sel(mem_sel_a),
    .oce0(oce0_a), .oce1(oce1_a), .ce0(ce0_a), .ce1(ce1_a), .wre0(wre0_a), .wre1(wre1_a),
    .ad0(ad0_a), .ad1(ad1_a), .din0(din0_a), .din1(din1_a), .dout0(dout0_a), .dout1(dout1_a),
    .m_data(m_data_a), .m_valid(m_valid_a), .m_ready(m_ready_a)
  );

  fft_qpsk_demap #(.FIRST_BIN(508), .LAST_BIN(515)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b), .mem_sel(mem_sel_b),
    .oce0(oce0_b), .oce1(oce1_b), .ce0(ce0_b), .ce1(ce1_b), .wre0(wre0_b), .wre1(wre1_b),
    .ad0(ad0_b), .ad1(ad1_b), .din0(din0_b), .din1(din1_b), .dout0(dout0_b), .dout1(dout1_b),
    .m_data(m_data_b), .m_valid(m_valid_b), .m_ready(m_ready_b)
  );

  // Two-stage BSRAM model: ce/ad at cycle c gives dout during cycle c+2.
  always @(posedge clk) begin
    if (ce0_a) s0_a <= mem0[ad0_a[8:0]];
    if (ce1_a) s1_a <= mem1[ad1_a[8:0]];
    if (ce0_b) s0_b <= mem0[ad0_b[8:0]];
    if (ce1_b) s1_b <= mem1[ad1_b[8:0]];
    dout0_a <= s0_a;
    dout1_a <= s1_a;
    dout0_b <= s0_b;
    dout1_b <= s1_b;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [1:0] ref_sym(input int k);
    logic [31:0] w;
    int re, im;
    w  = (k < 512) ? mem0[k] : mem1[k - 512];
    re = int'($signed(w[31:16]));
    im = int'($signed(w[15:0]));
    return {re < 0, im < 0};
  endfunction

  task automatic push_model_a(input int first, input int last);
    for (int g = first; g <= last; g += 4) begin
      int b;
      b = 0;
      for (int n = 0; n < 4; n++) b = b * 4 + int'(ref_sym(g + n));
      exp_a.push_back(8'(b));
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 7) == 0) w[31:16] = '0;
    if ($urandom_range(0, 7) == 0) w[15:0] = '0;
    return w;
  endfunction

  task automatic fill_all(input logic [31:0] w);
    for (int i = 0; i < 512; i++) begin
      mem0[i] = w;
      mem1[i] = w;
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 512; i++) begin
      mem0[i] = rand_word();
      mem1[i] = rand_word();
    end
  endtask

  initial begin
    m_ready_a = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      m_ready_a = rnd_ready ? ($urandom_range(0, 1) == 1) : ready_val;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      hold_pend_a = 1'b0;
    end else begin
      if (hold_pend_a) check("hold_a", 32'({m_valid_a, m_data_a}), 32'({1'b1, hold_data_a}));
      if (ce0_a || ce1_a) ce_cnt_a++;
      if (done_a) begin
        done_cnt_a++;
        check("done_after_last_a", exp_a.size(), 0);
      end
      if (m_valid_a && m_ready_a) begin
        bytes_a++;
        if (exp_a.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL extra_byte_a: got %02h, no byte expected", m_data_a);
        end else begin
          check("byte_a", 32'(m_data_a), 32'(exp_a.pop_front()));
        end
      end
      hold_pend_a = m_valid_a && !m_ready_a;
      hold_data_a = m_data_a;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (ce0_b && ce1_b) ce_both_b++;
      if (ce1_b) begin
        if (ce0_cnt_b < 4) ce_order_bad++;
        ad1_log.push_back(ad1_b);
      end
      if (ce0_b) begin
        ce0_cnt_b++;
        ad0_log.push_back(ad0_b);
      end
      if (done_b) done_cnt_b++;
      if (m_valid_b && m_ready_b) begin
        bytes_b++;
        if (exp_b.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL extra_byte_b: got %02h, no byte expected", m_data_b);
        end else begin
          check("byte_b", 32'(m_data_b), 32'(exp_b.pop_front()));
        end
      end
    end
  end

  // One frame on instance A; optional latency probe, second start while busy, and m_ready hold.
  task automatic run_a(input bit measure, input bit dbl_start, input int hold);
    int base_done, base_bytes, base_ce, ce_mid, first_ce, first_v, n, busy_bad;
    base_done  = done_cnt_a;
    base_bytes = bytes_a;
    base_ce    = ce_cnt_a;
    ce_mid     = 0;
    first_ce   = -1;
    first_v    = -1;
    busy_bad   = 0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    n = 1;
    while (done_cnt_a == base_done && n < 6000) begin
      if (first_ce < 0 && (ce0_a || ce1_a)) first_ce = n;
      if (first_v < 0 && m_valid_a) first_v = n;
      if (!busy_a || mem_sel_a) busy_bad++;
      start_a = dbl_start && (n == 10);
      if (hold > 0 && n == 20) ce_mid = ce_cnt_a;
      if (hold > 0 && n == hold) begin
        check("bp_reads_issued", ce_cnt_a - base_ce, 16);
        check("bp_no_more_reads", ce_cnt_a - ce_mid, 0);
        check("bp_valid_held", 32'(m_valid_a), 1);
        ready_val = 1'b1;
      end
      tick();
      n++;
    end
    start_a = 1'b0;
    check("done_seen_a", 32'(done_cnt_a != base_done), 1);
    if (measure) begin
      check("first_read_cycle", first_ce, 2);
      check("first_valid_cycle", first_v, 8);
    end
    check("busy_memsel_a", busy_bad, 0);
    check("idle_after_done_a", 32'({busy_a, mem_sel_a}), 32'h1);
    repeat (6) tick();
    check("done_once_a", done_cnt_a - base_done, 1);
    check("bytes_a", bytes_a - base_bytes, 256);
    check("exp_empty_a", exp_a.size(), 0);
    exp_a.delete();
  endtask

  initial begin
    int n, base_done;
    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    m_ready_b = 1'b1;
    fill_all(32'h0001_0001);
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_done", 32'(done_a), 0);
    check("rst_mem_sel", 32'(mem_sel_a), 1);
    check("rst_ce", 32'({ce0_a, ce1_a}), 0);
    check("rst_ad0", 32'(ad0_a), 0);
    check("rst_ad1", 32'(ad1_a), 0);
    check("rst_m_valid", 32'(m_valid_a), 0);
    check("rst_m_data", 32'(m_data_a), 0);
    check("const_oce_wre", 32'({oce0_a, oce1_a, wre0_a, wre1_a}), 32'hC);
    check("const_din", din0_a | din1_a, 0);
    check("rst_mem_sel_b", 32'(mem_sel_b), 1);
    #1 rst = 1'b0;
    tick();

    // Known-sign bins, all quadrants in byte 0.
    fill_all(32'h0001_0001);
    mem0[0] = 32'h0064_0064;
    mem0[1] = 32'h0064_FFCE;
    mem0[2] = 32'hFFFF_0007;
    mem0[3] = 32'h8000_8000;
    exp_a.push_back(8'h1B);
    repeat (255) exp_a.push_back(8'h00);
    run_a(1'b1, 1'b0, 0);

    // Zero counts as non-negative.
    fill_all(32'h0001_0001);
    mem0[0] = 32'h0000_0000;
    mem0[1] = 32'h0000_FFFF;
    mem0[2] = 32'hFFFF_0000;
    mem0[3] = 32'h0000_0000;
    exp_a.push_back(8'h18);
    repeat (255) exp_a.push_back(8'h00);
    run_a(1'b0, 1'b0, 0);

    // Backpressure: m_ready low for 50 cycles after start.
    fill_random();
    push_model_a(0, 1023);
    ready_val = 1'b0;
    tick();
    tick();
    run_a(1'b0, 1'b0, 50);

    // Random m_ready, random contents, two frames.
    rnd_ready = 1'b1;
    for (int f = 0; f < 2; f++) begin
      fill_random();
      push_model_a(0, 1023);
      run_a(1'b0, 1'b0, 0);
    end

    // Reset mid-READ, then a clean restart with an ignored second start.
    fill_random();
    push_model_a(0, 1023);
    base_done = done_cnt_a;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (30) tick();
    rst = 1'b1;
    #1;
    check("midrst_mem_sel", 32'(mem_sel_a), 1);
    check("midrst_m_valid", 32'(m_valid_a), 0);
    check("midrst_busy_ce", 32'({busy_a, ce0_a, ce1_a}), 0);
    exp_a.delete();
    tick();
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("midrst_no_done", done_cnt_a - base_done, 0);
    rnd_ready = 1'b0;
    ready_val = 1'b1;
    push_model_a(0, 1023);
    run_a(1'b0, 1'b1, 0);

    // Bank crossing on instance B: bins 508..515.
    for (int i = 508; i < 512; i++) mem0[i] = 32'hFFFB_0005;
    for (int i = 0; i < 4; i++) mem1[i] = 32'h0005_FFFB;
    exp_b.push_back(8'hAA);
    exp_b.push_back(8'h55);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    n = 0;
    while (done_cnt_b == 0 && n < 200) begin
      tick();
      n++;
    end
    check("done_seen_b", 32'(done_cnt_b), 1);
    check("bytes_b", bytes_b, 2);
    check("exp_empty_b", exp_b.size(), 0);
    check("ce_order_b", ce_order_bad, 0);
    check("ce_overlap_b", ce_both_b, 0);
    check("ad0_count_b", ad0_log.size(), 4);
    check("ad1_count_b", ad1_log.size(), 4);
    for (int i = 0; i < 4 && i < ad0_log.size(); i++) check("ad0_seq_b", 32'(ad0_log[i]), 508 + i);
    for (int i = 0; i < 4 && i < ad1_log.size(); i++) check("ad1_seq_b", 32'(ad1_log[i]), i);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fft_qpsk_demap.md
Name: fft_qpsk_demap

Overview:
Downstream stage of fft1024. Takes ownership of both FFT result BSRAM banks after the FFT finishes, and reads bins FIRST_BIN..LAST_BIN in order. Makes a hard QPSK decision per bin and packs 4 symbols per byte onto a valid/ready byte stream toward the OFDM bit sink. Drives the BSRAM mux select, so the FFT and this block never share a bank.

Parameters:
FIRST_BIN, 0, first subcarrier index (0..1023)
LAST_BIN, 1023, last subcarrier index, inclusive; (LAST_BIN-FIRST_BIN+1) must be a multiple of 4
READ_LATENCY, 2, BSRAM cycles from ad/ce to valid dout (oce tied 1, pipeline mode)
FIFO_DEPTH, 4, output byte FIFO entries (power of 2, >=2)

Ports:
clk  in  1  system clock (27 MHz)
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; wired to fft1024 finish
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse when the last byte has been handshaken
mem_sel  out  1  BSRAM mux select: 1 = fft1024 owns the banks, 0 = this block
oce0/oce1  out  1  bank output-register enable, constant 1
ce0/ce1  out  1  bank clock enable
wre0/wre1  out  1  write enable, constant 0
ad0/ad1  out  11  bank address
din0/din1  out  32  write data, constant 0
dout0/dout1  in  32  bank read data: [31:16] real, [15:0] imag, signed two's complement
m_data  out  8  packed symbols
m_valid  out  1  m_data valid
m_ready  in  1  downstream ready

Behaviour:
- Reset values: busy=0, done=0, mem_sel=1, ce0=ce1=0, ad0=ad1=0, m_valid=0, m_data=0. Counters, packer and FIFO are cleared.
- States: IDLE, GRAB, READ, DRAIN.
- IDLE: start=1 -> GRAB. Set busy=1 and mem_sel=0. start seen in any other state is ignored.
- GRAB: one cycle for the mux to settle. Load k=FIRST_BIN. Go to READ.
- Bin mapping: bank=k[9], address={2'b00,k[8:0]}. Only the selected bank's ce is pulsed; the other bank's ce stays 0. ad of the unselected bank holds its last value.
- READ issue rule: issue one read per cycle while credit>0.
  - credit (in symbols) = 4*FIFO_DEPTH - 4*fifo_occupancy - reads_in_flight - symbols_in_packer.
  - The FIFO therefore never overflows.
- After the read of k=LAST_BIN is issued, go to DRAIN.
- Return path: the bank bit is delayed by READ_LATENCY; dout is taken from the matching bank exactly READ_LATENCY cycles after issue.
- Decision per symbol: b1 = real[15] (1 if real<0), b0 = imag[15]. Zero counts as non-negative, giving 0.
- Packing: MSB first. Symbol n of a group goes to m_data[7-2n:6-2n], n=0..3. After the 4th symbol the byte is pushed into the FIFO on the same cycle.
- Output: FWFT FIFO. m_valid=!empty. An entry pops when m_valid && m_ready. m_data must stay stable while m_valid && !m_ready.
- DRAIN: waits until no reads are in flight, the packer is empty and the FIFO is empty. Then, in one cycle: done=1, busy=0, mem_sel=1, return to IDLE.
- Total bytes per frame = (LAST_BIN-FIRST_BIN+1)/4; 256 with defaults.
- Throughput: with m_ready=1, one symbol per cycle after READ_LATENCY fill.
- Latency, defaults, m_ready=1: start at cycle 0 -> first read issued at cycle 2 -> first byte m_valid at cycle 2+READ_LATENCY+4 = cycle 8.
- rst during any state: immediate return to IDLE with reset values; mem_sel=1 hands the banks back. No byte is emitted, no done.

Decomposition:
- Shared package holds:
  - NUM_BINS=1024, BANK_DEPTH=512, ADDR_W=11, SAMPLE_W=16, WORD_W=32
  - state encoding
  - field slices for real/imag within the 32-bit word
- Sub-module byte_fifo holds the output FIFO: FWFT, parameter DEPTH, width 8, with count output used for the credit calculation.

Test Plan:
- Default params, bins k=0..3 preloaded as (+100,+100), (+100,-50), (-1,+7), (-32768,-32768), all other bins (+1,+1), m_ready=1 -> first byte 8'b00_01_10_11 = 8'h1B, then 255 bytes of 8'h00; done pulses once after byte 256; mem_sel=0 throughout busy.
- Bank crossing: FIRST_BIN=508, LAST_BIN=515; bank0 addr508..511 all (-5,+5), bank1 addr0..3 all (+5,-5) -> bytes 8'hAA then 8'h55; ce1 never asserted before ce0's 4th read; ad1 sequence 0,1,2,3.
- Backpressure: m_ready=0 for 50 cycles after start -> exactly FIFO_DEPTH=4 bytes queued, no further ce pulses; m_data stable; after release, byte sequence identical to the m_ready=1 run.
- Random m_ready (50% duty), random bank contents -> output stream matches reference model byte-for-byte; done only after the final handshake.
- Zero handling: bins (0,0), (0,-1), (-1,0), (0,0) -> byte 8'b00_01_10_00 = 8'h18.
- rst asserted mid-READ, then start re-issued -> mem_sel=1 and m_valid=0 on reset; the second run emits the full 256 bytes from bin FIRST_BIN; start pulsed while busy is ignored (single done).
